// File: rtl/ws2812_chain_ctl.sv
// ws2812_chain_ctl
// Walks a linked list of LED records held in an external synchronous RAM and
// streams each pixel MSB-first to a single-wire bit encoder using a
// ready/done handshake. After the last record it holds the line low for a
// programmable latch period. Each record is {next_address, pixel}. A link
// value of 0 ends the chain, so address 0 is still valid as the first record.
// A loop guard stops a frame once 2^ADDR_W LEDs have been sent.
module ws2812_chain_ctl #(
    parameter int PIX_W   = 24,     // 24 = GRB, 32 = GRBW
    parameter int ADDR_W  = 6,      // RAM address width
    parameter int RD_LAT  = 1,      // RAM read latency in clocks, 1..4
    parameter int CNT_RST = 10000   // latch period in clocks, >= 2
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      frame_rdy_in,
    input  logic                      abort_in,
    input  logic [ADDR_W-1:0]         start_addr_in,
    output logic                      rd_en_out,
    output logic [ADDR_W-1:0]         rd_addr_out,
    input  logic [ADDR_W+PIX_W-1:0]   rd_data_in,
    input  logic                      bit_done_in,
    output logic                      bit_rdy_out,
    output logic                      bit_data_out,
    output logic                      busy_out,
    output logic                      frame_done_out,
    output logic                      overflow_out,
    output logic [ADDR_W:0]           led_cnt_out
);

    localparam int SEL_W = $clog2(PIX_W);
    localparam int DLY_W = $clog2(RD_LAT + 1);
    localparam int LAT_W = $clog2(CNT_RST);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(PIX_W - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(RD_LAT);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CNT_RST - 1);
    localparam logic [ADDR_W:0]  LED_MAX  = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_LATCH
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   rd_addr_q;     // address of the record being fetched
    logic [ADDR_W-1:0]   next_addr_q;   // link field of the record being sent
    logic [PIX_W-1:0]    shift_q;       // pixel, current bit in the MSB
    logic [SEL_W-1:0]    bit_sel_q;     // index of the bit now on the line
    logic [DLY_W-1:0]    dly_q;         // RAM latency wait in FETCH
    logic [LAT_W-1:0]    lat_cnt_q;     // latch period counter
    logic [ADDR_W:0]     led_cnt_q;
    logic                rd_en_q;
    logic                bit_rdy_q;
    logic                bit_data_q;
    logic                busy_q;
    logic                frame_done_q;
    logic                overflow_q;

    // Record fields and derived next-state values.
    logic [PIX_W-1:0]    rd_pixel;
    logic [ADDR_W-1:0]   rd_link;
    logic                last_bit;
    logic [ADDR_W:0]     led_cnt_d;

    assign rd_pixel  = rd_data_in[PIX_W-1:0];
    assign rd_link   = rd_data_in[ADDR_W+PIX_W-1:PIX_W];
    assign last_bit  = (bit_sel_q == LAST_SEL);
    assign led_cnt_d = led_cnt_q + 1'b1;

    // Frame sequencer: fetch record, shift its pixel out, follow the link,
    // finish with the latch period. All outputs come straight from registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            rd_addr_q    <= '0;
            next_addr_q  <= '0;
            shift_q      <= '0;
            bit_sel_q    <= '0;
            dly_q        <= '0;
            lat_cnt_q    <= '0;
            led_cnt_q    <= '0;
            rd_en_q      <= 1'b0;
            bit_rdy_q    <= 1'b0;
            bit_data_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // reads the pre-edge register values; the defaults here make the
            // strobes single-cycle pulses unless a branch re-asserts them.
            rd_en_q      <= 1'b0;
            bit_rdy_q    <= 1'b0;
            frame_done_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (frame_rdy_in) begin
                        rd_addr_q  <= start_addr_in;
                        led_cnt_q  <= '0;
                        overflow_q <= 1'b0;
                        dly_q      <= '0;
                        rd_en_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    if (abort_in) begin
                        // Whatever the RAM returns for this read is dropped.
                        lat_cnt_q  <= '0;
                        bit_data_q <= 1'b0;
                        state_q    <= ST_LATCH;
                    end else if (dly_q == DLY_LAST) begin
                        shift_q     <= rd_pixel;
                        next_addr_q <= rd_link;
                        bit_sel_q   <= '0;
                        bit_data_q  <= rd_pixel[PIX_W-1];
                        bit_rdy_q   <= 1'b1;
                        state_q     <= ST_SEND;
                    end else begin
                        dly_q <= dly_q + 1'b1;
                    end
                end

                ST_SEND: begin
                    if (bit_done_in && last_bit) begin
                        // The LED is complete even if abort arrives now.
                        led_cnt_q <= led_cnt_d;
                        if (abort_in || next_addr_q == '0) begin
                            lat_cnt_q  <= '0;
                            bit_data_q <= 1'b0;
                            state_q    <= ST_LATCH;
                        end else if (led_cnt_d == LED_MAX) begin
                            // Every address has been visited: the chain loops.
                            overflow_q <= 1'b1;
                            lat_cnt_q  <= '0;
                            bit_data_q <= 1'b0;
                            state_q    <= ST_LATCH;
                        end else begin
                            rd_addr_q <= next_addr_q;
                            dly_q     <= '0;
                            rd_en_q   <= 1'b1;
                            state_q   <= ST_FETCH;
                        end
                    end else if (abort_in) begin
                        // Partial LED: no count, no further bits.
                        lat_cnt_q  <= '0;
                        bit_data_q <= 1'b0;
                        state_q    <= ST_LATCH;
                    end else if (bit_done_in) begin
                        shift_q    <= {shift_q[PIX_W-2:0], 1'b0};
                        bit_data_q <= shift_q[PIX_W-2];
                        bit_sel_q  <= bit_sel_q + 1'b1;
                        bit_rdy_q  <= 1'b1;
                    end
                end

                ST_LATCH: begin
                    if (lat_cnt_q == LAT_LAST) begin
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_en_out      = rd_en_q;
    assign rd_addr_out    = rd_addr_q;
    assign bit_rdy_out    = bit_rdy_q;
    assign bit_data_out   = bit_data_q;
    assign busy_out       = busy_q;
    assign frame_done_out = frame_done_q;
    assign overflow_out   = overflow_q;
    assign led_cnt_out    = led_cnt_q;

endmodule
